fetch_stage: RTL

//  - IF stage upstream of the IF/ID boundary: owns the PC, drives the combinational

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer between IF and ID; flush clears pointers and count
// but leaves storage untouched (the empty head is masked by the caller).
module fetch_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem access and a 2-entry buffer towards decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              imem_en,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_target,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc4,
    output logic [WORD_W-1:0] perf_fetched,
    output logic [WORD_W-1:0] perf_stalls,
    output logic [WORD_W-1:0] perf_flushes
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic              push, pop;
    logic [1:0]        count;
    fetch_entry_t      head, wr_entry;

    // A redirect suppresses the fetch at the old PC; a pop frees a slot in the same cycle.
    always_comb begin
        pop      = id_valid && id_ready;
        push     = !br_taken && ((count < 2'(FIFO_DEPTH)) || pop);
        wr_entry = '{instr: imem_rdata, pc4: pc_q + PC_STEP};
        pc_d     = pc_q;
        if (br_taken) begin
            pc_d = {br_target[WORD_W-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (br_taken),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    assign imem_addr = pc_q;
    assign imem_en   = push;
    assign id_valid  = (count != 2'd0);
    assign id_instr  = id_valid ? head.instr : INSTR_NOP;
    assign id_pc4    = id_valid ? head.pc4 : '0;

`ifdef FETCH_PERF_EN
    logic [WORD_W-1:0] fetched_q, fetched_d;
    logic [WORD_W-1:0] stalls_q, stalls_d;
    logic [WORD_W-1:0] flushes_q, flushes_d;

    always_comb begin
        fetched_d = fetched_q + WORD_W'(push);
        stalls_d  = stalls_q + WORD_W'(id_valid && !id_ready);
        flushes_d = flushes_q + WORD_W'(br_taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule
